paddsb_seq: RTL and testbench
=============================

// Module: paddsb_seq
// PURPOSE
//  Multicycle sequencer for the PADDSB (parallel nibble saturating add) operation.
//  - Accepts one 16-bit operand pair over a valid/ready handshake.
//  - Processes the four 4-bit lanes through a shared saturating nibble adder, LANES_PER_CYCLE lanes per cycle.
//  - Returns the packed 16-bit result and per-lane saturation flags over a second valid/ready handshake.
//  - Sits between the EX-stage issue logic and writeback as an area-reduced PADDSB unit.
// PARAMETERS
//  LANES_PER_CYCLE  1  nibble lanes computed per CALC cycle; legal values 1, 2, 4 (others: elaboration $error)
//  SAT_EN           1  1 = signed saturation per lane; 0 = plain 4-bit wrap-around add
// PORTS
//  clk       in   1   single clock, all state updates on rising edge
//  rst_n     in   1   asynchronous active-low reset
//  in_valid  in   1   operand pair offered
//  in_ready  out  1   block can accept operands (high only in IDLE)
//  op_t      in   16  operand T, lanes [3:0],[7:4],[11:8],[15:12]
//  op_s      in   16  operand S, same lane layout
//  out_valid out  1   result available
//  out_ready in   1   consumer accepts result
//  out_d     out  16  packed result D
//  out_sat   out  4   bit i = lane i saturated (always 0 when SAT_EN=0)
//  busy      out  1   high in CALC or DONE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, lane counter=0, operand regs=0.
//   Outputs: out_d=0, out_sat=0, out_valid=0, busy=0, in_ready=1 after release.
//  Lane arithmetic: lane_sum = sign-extended 5-bit T_i + S_i.
//   SAT_EN=1: sum > 7 -> 4'h7; sum < -8 -> 4'h8; flag set on either clamp.
//   Otherwise D_i = sum[3:0].
//  FSM, states IDLE, CALC, DONE:
//   IDLE: in_ready=1. On rising edge with in_valid&&in_ready: capture op_t/op_s, clear counter and flags, go CALC.
//   CALC: each cycle compute lanes cnt..cnt+L-1 (L=LANES_PER_CYCLE) into an internal accumulator; cnt += L.
//    On the edge completing lane 3: load accumulator into out_d/out_sat, go DONE.
//   DONE: out_valid=1. out_d/out_sat are held stable until the out_valid&&out_ready edge, then go IDLE.
//  Latency: out_valid rises exactly 4/L cycles after the accepting edge (L=1:4, L=2:2, L=4:1).
//  Throughput: in_ready is low in CALC and DONE; no overlap.
//   Minimum spacing between accepts is 4/L+2 cycles when out_ready is held high.
//  Stability:
//   - op_t/op_s changes after the accept edge have no effect.
//   - out_d/out_sat change only on the CALC->DONE edge; between ops they hold the last result.
//  Boundaries:
//   - out_ready=1 in IDLE/CALC is ignored.
//   - in_valid held high in DONE is not accepted until the cycle after returning to IDLE.
//   - out_ready low in DONE stalls indefinitely.
//  Reset asserted mid-CALC/DONE: operation is discarded, outputs go to reset values immediately.
// TESTING
//  1. L=1, accept 16'h1234/16'h1111 -> out_valid 4 cycles after accept, out_d=16'h2345, out_sat=4'b0000.
//  2. SAT_EN=1, 16'h7FFF/16'h1000 -> out_d=16'h7FFF, out_sat=4'b1000.
//     Same operands with SAT_EN=0 -> out_d=16'h8FFF, out_sat=0.
//  3. 16'h8000/16'h8000 -> out_d=16'h8000, out_sat=4'b1000.
//     16'h444F/16'h1111 -> out_d=16'h5550, out_sat=0.
//  4. Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling op_t and in_valid.
//     -> out_valid stays 1, out_d unchanged, in_ready=0. Release: one handshake, then IDLE.
//  5. L=2 and L=4 builds, test 1 operands -> out_valid after 2 and 1 cycles respectively, out_d=16'h2345.
//  6. Drop rst_n during CALC cycle 2 -> out_valid=0, busy=0, out_d=0 that cycle.
//     After release, a new op 16'h0001/16'h0001 -> out_d=16'h0002.

Source files
------------

// File: rtl/paddsb_seq_if.sv
// Operand/result handshake bundle for the PADDSB sequencer.
// Carries both valid/ready channels: operand pair in, packed result and flags out.
// master = issue/writeback side, slave = sequencer side.
interface paddsb_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_t;
    logic [15:0] op_s;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_d;
    logic [3:0]  out_sat;

    modport master (
        output in_valid, op_t, op_s, out_ready,
        input  in_ready, out_valid, out_d, out_sat
    );

    modport slave (
        input  in_valid, op_t, op_s, out_ready,
        output in_ready, out_valid, out_d, out_sat
    );
endinterface

// File: rtl/paddsb_seq.sv
// Multicycle PADDSB: four signed nibble lanes through LANES_PER_CYCLE shared saturating adders.
// Latency: out_valid rises 4/LANES_PER_CYCLE cycles after the accept edge; one op in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, stalls indefinitely.
module paddsb_seq #(
    parameter int LANES_PER_CYCLE = 1,
    parameter bit SAT_EN          = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    paddsb_seq_if.slave bus,
    output logic        busy
);

    if (!(LANES_PER_CYCLE == 1 || LANES_PER_CYCLE == 2 || LANES_PER_CYCLE == 4)) begin : g_bad_lanes
        $error("paddsb_seq: LANES_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] opt_q, opt_d;
    logic [15:0] ops_q, ops_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  acc_sat_q, acc_sat_d;
    logic [15:0] out_d_q, out_d_d;
    logic [3:0]  out_sat_q, out_sat_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;

    // Lanes produced by this CALC cycle merged into the running accumulator
    logic [15:0] acc_nx;
    logic [3:0]  sat_nx;
    logic [1:0]  lane;
    logic [4:0]  lane_res;
    logic        last_step;

    // Returns {clamp_flag, lane_result}; overflow is detected as bit4 != bit3 of the 5-bit sum
    function automatic logic [4:0] lane_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] sum;
        sum = {a[3], a} + {b[3], b};
        if (SAT_EN && (sum[4] != sum[3])) begin
            lane_add = sum[4] ? 5'b1_1000 : 5'b1_0111;
        end else begin
            lane_add = {1'b0, sum[3:0]};
        end
    endfunction

    // Shared nibble adders: lanes cnt..cnt+L-1 of the captured operands
    always_comb begin
        acc_nx   = acc_q;
        sat_nx   = acc_sat_q;
        lane     = 2'd0;
        lane_res = 5'd0;
        for (int j = 0; j < LANES_PER_CYCLE; j++) begin
            lane     = cnt_q + 2'(j);
            lane_res = lane_add(opt_q[{lane, 2'b00} +: 4], ops_q[{lane, 2'b00} +: 4]);
            acc_nx[{lane, 2'b00} +: 4] = lane_res[3:0];
            sat_nx[lane]               = lane_res[4];
        end
        last_step = (({1'b0, cnt_q} + 3'(LANES_PER_CYCLE)) == 3'd4);
    end

    // Next-state and next-output logic for the IDLE/CALC/DONE sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opt_d       = opt_q;
        ops_d       = ops_q;
        acc_d       = acc_q;
        acc_sat_d   = acc_sat_q;
        out_d_d     = out_d_q;
        out_sat_d   = out_sat_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    opt_d      = bus.op_t;
                    ops_d      = bus.op_s;
                    cnt_d      = 2'd0;
                    acc_d      = 16'd0;
                    acc_sat_d  = 4'd0;
                    state_d    = ST_CALC;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_CALC: begin
                acc_d     = acc_nx;
                acc_sat_d = sat_nx;
                cnt_d     = cnt_q + 2'(LANES_PER_CYCLE);
                if (last_step) begin
                    out_d_d     = acc_nx;
                    out_sat_d   = sat_nx;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset discards any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            opt_q       <= 16'd0;
            ops_q       <= 16'd0;
            acc_q       <= 16'd0;
            acc_sat_q   <= 4'd0;
            out_d_q     <= 16'd0;
            out_sat_q   <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opt_q       <= opt_d;
            ops_q       <= ops_d;
            acc_q       <= acc_d;
            acc_sat_q   <= acc_sat_d;
            out_d_q     <= out_d_d;
            out_sat_q   <= out_sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_d     = out_d_q;
    assign bus.out_sat   = out_sat_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_paddsb_seq.sv
// Bench for paddsb_seq: four builds (L=1 sat, L=1 wrap, L=2 sat, L=4 sat) share one stimulus.
// Results are compared against a lane-by-lane integer model of the nibble add.
// Latency, hold, backpressure and mid-op reset are checked per build.
module tb_paddsb_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] op_t = 16'd0;
    logic [15:0] op_s = 16'd0;

    logic        in_rdy_a  [4];
    logic        out_vld_a [4];
    logic        busy_a    [4];
    logic [15:0] d_a       [4];
    logic [3:0]  sat_a     [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int GL = (g == 2) ? 2 : ((g == 3) ? 4 : 1);
        localparam bit GS = (g == 1) ? 1'b0 : 1'b1;
        paddsb_seq_if u_if ();
        assign u_if.in_valid  = in_valid;
        assign u_if.op_t      = op_t;
        assign u_if.op_s      = op_s;
        assign u_if.out_ready = out_ready;
        assign in_rdy_a[g]    = u_if.in_ready;
        assign out_vld_a[g]   = u_if.out_valid;
        assign d_a[g]         = u_if.out_d;
        assign sat_a[g]       = u_if.out_sat;
        paddsb_seq #(.LANES_PER_CYCLE(GL), .SAT_EN(GS)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if),
            .busy  (busy_a[g])
        );
    end

    function automatic int lanes_of(input int k);
        return (k == 2) ? 2 : ((k == 3) ? 4 : 1);
    endfunction

    function automatic bit sat_of(input int k);
        return (k != 1);
    endfunction

    // Each nibble as a signed integer, added, then clamped or wrapped
    function automatic void model(input logic [15:0] t, input logic [15:0] s, input bit sat,
                                  output logic [15:0] d, output logic [3:0] f);
        int a, b, sum;
        d = 16'd0;
        f = 4'd0;
        for (int i = 0; i < 4; i++) begin
            a = int'(t[i*4 +: 4]);
            b = int'(s[i*4 +: 4]);
            if (a > 7) a = a - 16;
            if (b > 7) b = b - 16;
            sum = a + b;
            if (sat && sum > 7) begin
                sum = 7;
                f[i] = 1'b1;
            end else if (sat && sum < -8) begin
                sum = -8;
                f[i] = 1'b1;
            end
            d[i*4 +: 4] = 4'(sum & 15);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit all_rdy;
        all_rdy = 1'b0;
        for (int c = 0; c < 20 && !all_rdy; c++) begin
            all_rdy = 1'b1;
            for (int k = 0; k < 4; k++) if (in_rdy_a[k] !== 1'b1) all_rdy = 1'b0;
            if (!all_rdy) step();
        end
        checks++;
        if (!all_rdy) begin
            errors++;
            $display("FAIL wait_idle: in_ready never returned high within 20 cycles");
        end
    endtask

    task automatic run_op(input logic [15:0] t, input logic [15:0] s, input string name);
        int          lat [4];
        logic [15:0] ed  [4];
        logic [3:0]  ef  [4];
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            model(t, s, sat_of(k), ed[k], ef[k]);
            lat[k] = -1;
        end
        in_valid  = 1'b1;
        op_t      = t;
        op_s      = s;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        op_t     = 16'($urandom);
        op_s     = 16'($urandom);
        for (int c = 1; c <= 8; c++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                if (out_vld_a[k] === 1'b1 && lat[k] < 0) begin
                    lat[k] = c;
                    checks++;
                    if (d_a[k] !== ed[k]) begin
                        errors++;
                        $display("FAIL %s dut%0d out_d: got %h want %h (t=%h s=%h)", name, k, d_a[k], ed[k], t, s);
                    end
                    checks++;
                    if (sat_a[k] !== ef[k]) begin
                        errors++;
                        $display("FAIL %s dut%0d out_sat: got %b want %b (t=%h s=%h)", name, k, sat_a[k], ef[k], t, s);
                    end
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lat[k] != 4 / lanes_of(k)) begin
                errors++;
                $display("FAIL %s dut%0d latency: got %0d want %0d", name, k, lat[k], 4 / lanes_of(k));
            end
            checks++;
            if (d_a[k] !== ed[k]) begin
                errors++;
                $display("FAIL %s dut%0d hold out_d: got %h want %h", name, k, d_a[k], ed[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_vld_a[k] !== 1'b0 || busy_a[k] !== 1'b0 || d_a[k] !== 16'd0 || sat_a[k] !== 4'd0) begin
                errors++;
                $display("FAIL reset dut%0d: vld=%b busy=%b d=%h sat=%b want 0 0 0000 0000",
                         k, out_vld_a[k], busy_a[k], d_a[k], sat_a[k]);
            end
        end
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (in_rdy_a[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready dut%0d: got %b want 1", k, in_rdy_a[k]);
            end
        end
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h1111, "plain");
        run_op(16'h7FFF, 16'h1000, "sat_pos");
        run_op(16'h8000, 16'h8000, "sat_neg");
        run_op(16'h444F, 16'h1111, "wrap_zero");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) run_op(16'($urandom), 16'($urandom), "random");
    endtask

    task automatic test_back_to_back();
        logic [15:0] t, s, t2, s2;
        logic [15:0] ed [4];
        logic [3:0]  ef [4];
        bit          all_vld;
        t  = 16'($urandom);
        s  = 16'($urandom);
        t2 = 16'($urandom);
        s2 = 16'($urandom);
        wait_idle();
        for (int k = 0; k < 4; k++) model(t, s, sat_of(k), ed[k], ef[k]);
        in_valid  = 1'b1;
        op_t      = t;
        op_s      = s;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        all_vld  = 1'b0;
        for (int c = 0; c < 8 && !all_vld; c++) begin
            step();
            all_vld = 1'b1;
            for (int k = 0; k < 4; k++) if (out_vld_a[k] !== 1'b1) all_vld = 1'b0;
        end
        checks++;
        if (!all_vld) begin
            errors++;
            $display("FAIL stall_reach_done: out_valid not high on all builds within 8 cycles");
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = cyc[0];
            op_t     = 16'($urandom);
            op_s     = 16'($urandom);
            out_ready = 1'b0;
            step();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (out_vld_a[k] !== 1'b1 || in_rdy_a[k] !== 1'b0 || d_a[k] !== ed[k] || sat_a[k] !== ef[k]) begin
                    errors++;
                    $display("FAIL stall dut%0d cyc%0d: vld=%b rdy=%b d=%h sat=%b want 1 0 %h %b",
                             k, cyc, out_vld_a[k], in_rdy_a[k], d_a[k], sat_a[k], ed[k], ef[k]);
                end
            end
        end
        op_t      = t2;
        op_s      = s2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_vld_a[k] !== 1'b0 || in_rdy_a[k] !== 1'b1 || busy_a[k] !== 1'b0) begin
                errors++;
                $display("FAIL release dut%0d: vld=%b rdy=%b busy=%b want 0 1 0",
                         k, out_vld_a[k], in_rdy_a[k], busy_a[k]);
            end
        end
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (busy_a[k] !== 1'b1 || in_rdy_a[k] !== 1'b0) begin
                errors++;
                $display("FAIL reaccept dut%0d: busy=%b rdy=%b want 1 0", k, busy_a[k], in_rdy_a[k]);
            end
            model(t2, s2, sat_of(k), ed[k], ef[k]);
        end
        for (int c = 0; c < 6; c++) step();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_a[k] !== ed[k] || sat_a[k] !== ef[k] || in_rdy_a[k] !== 1'b1) begin
                errors++;
                $display("FAIL reaccept_result dut%0d: d=%h sat=%b rdy=%b want %h %b 1",
                         k, d_a[k], sat_a[k], in_rdy_a[k], ed[k], ef[k]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        wait_idle();
        in_valid  = 1'b1;
        op_t      = 16'h7777;
        op_s      = 16'h7777;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_vld_a[k] !== 1'b0 || busy_a[k] !== 1'b0 || d_a[k] !== 16'd0 || sat_a[k] !== 4'd0) begin
                errors++;
                $display("FAIL mid_reset dut%0d: vld=%b busy=%b d=%h sat=%b want 0 0 0000 0000",
                         k, out_vld_a[k], busy_a[k], d_a[k], sat_a[k]);
            end
        end
        step();
        rst_n = 1'b1;
        step();
        run_op(16'h0001, 16'h0001, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
